// File: rtl/pixel_pkg.sv
// pixel_pkg: shared FSM states, frame defaults and pixel type for the frame writer
package pixel_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef logic [23:0] pixel_t;
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;
    localparam int ADDR_W = 19;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: power-of-two ring buffer exposing the head and the entry behind it
module pixel_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_nxt = rd_ptr + 1'b1;
    assign head = mem[rd_ptr];
    assign next = mem[rd_nxt];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointer and occupancy bookkeeping; clr empties the buffer for a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_nxt;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage needs no reset: empty pointers make stale entries unreachable
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: buffers one frame of streamed pixels and writes them to memory
module pixel_frame_writer
    import pixel_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_data,
    input  logic        i_valid,
    output logic [18:0] o_address,
    output logic [23:0] o_writedata,
    output logic        o_write,
    input  logic        i_waitrequest,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_overflow
);
    localparam int XW = $clog2(H_ACT + 1);
    localparam int YW = $clog2(V_ACT + 1);
    localparam int FW = ADDR_W + 24;
    state_t state, state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ADDR_W-1:0] pix_addr;
    logic [FW-1:0] head, next;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic full, empty, start, accept, last_px, complete;
    pixel_t pix;
    assign pix = i_data;
    assign start = state == S_IDLE && i_start;
    assign accept = state == S_RUN && i_valid;
    assign last_px = x == XW'(H_ACT - 1) && y == YW'(V_ACT - 1);
    assign complete = o_write && !i_waitrequest;
    assign o_busy = state != S_IDLE;
    assign o_frame_done = state == S_DONE;

    // the entry on the bus stays counted in the FIFO until its transfer completes
    pixel_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(i_clk),
        .rst(i_rst),
        .clr(start),
        .push(accept && !full),
        .wdata({pix_addr, pix}),
        .pop(complete),
        .head(head),
        .next(next),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else state <= state_nxt;
    end

    // next-state: the last raster position ends capture even if that pixel was dropped
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = i_start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = (accept && last_px) ? S_DRAIN : S_RUN;
            S_DRAIN: state_nxt = (empty && !o_write) ? S_DONE : S_DRAIN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // raster position and running write address advance on every valid pixel in S_RUN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || start) begin
            x <= '0;
            y <= '0;
            pix_addr <= ADDR_W'(BASE_ADDR);
        end else if (accept) begin
            pix_addr <= pix_addr + 1'b1;
            x <= (x == XW'(H_ACT - 1)) ? '0 : x + 1'b1;
            y <= (x == XW'(H_ACT - 1)) ? y + 1'b1 : y;
        end
    end

    // sticky drop flag, cleared only when a new frame is armed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || start) o_overflow <= 1'b0;
        else if (accept && full) o_overflow <= 1'b1;
    end

    // bus register: reload from the next entry on completion for one write per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_write <= 1'b0;
            o_address <= ADDR_W'(BASE_ADDR);
            o_writedata <= '0;
        end else if (start) begin
            o_write <= 1'b0;
        end else if (complete) begin
            o_write <= count > 1;
            if (count > 1) {o_address, o_writedata} <= next;
        end else if (!o_write && !empty) begin
            o_write <= 1'b1;
            {o_address, o_writedata} <= head;
        end
    end
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: scoreboard bench for the frame writer on a 4x4 frame
module tb_pixel_frame_writer;
    localparam int N = 16;
    localparam int BASE = 100;
    logic        clk = 0;
    logic        i_rst = 1;
    logic        i_start = 0;
    logic [23:0] i_data = '0;
    logic        i_valid = 0;
    logic [18:0] o_address;
    logic [23:0] o_writedata;
    logic        o_write;
    logic        i_waitrequest = 0;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_overflow;
    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, done_gap = 0, wr_cnt = 0, wr_mark = 0, first_wr = 0, last_wr = 0;
    int idx = 0;
    bit armed = 0;
    logic [42:0] q[$];
    logic [42:0] e;

    pixel_frame_writer #(.H_ACT(4), .V_ACT(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_address(o_address),
        .o_writedata(o_writedata),
        .o_write(o_write),
        .i_waitrequest(i_waitrequest),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input bit drop = 0);
        i_valid = 1;
        i_data = d;
        if (armed) begin
            if (!drop) q.push_back({19'(BASE + idx), d});
            idx++;
            if (idx == N) armed = 0;
        end
        tick(1);
        i_valid = 0;
        i_data = '0;
    endtask

    task automatic start_frame();
        i_start = 1;
        if (!armed) begin
            armed = 1;
            idx = 0;
        end
        tick(1);
        i_start = 0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            tick(1);
            t++;
        end
        chk("done_cnt", done_cnt, d0 + 1);
        chk("done_gap", done_gap, 2);
        chk("sb_empty", q.size(), 0);
        chk("busy_after", o_busy, 0);
    endtask

    // scoreboard: a write completes at the next rising edge when seen here
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_frame_done) begin
                done_cnt++;
                done_gap = cyc - last_wr;
            end
            if (o_write && !i_waitrequest) begin
                chk("wr_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("wr_addr", o_address, e[42:24]);
                    chk("wr_data", o_writedata, e[23:0]);
                end
                if (wr_cnt == wr_mark) first_wr = cyc;
                last_wr = cyc;
                wr_cnt++;
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_write", o_write, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_addr", o_address, BASE);
        chk("rst_wdata", o_writedata, 0);
        i_rst = 0;
        tick(2);

        wr_mark = wr_cnt;
        for (int k = 0; k < 5; k++) send(24'h0A0000 + 24'(k));
        tick(5);
        chk("idle_writes", wr_cnt - wr_mark, 0);
        chk("idle_busy", o_busy, 0);

        start_frame();
        chk("run_busy", o_busy, 1);
        for (int k = 0; k < N; k++) begin
            send(24'h110000 + 24'(k * 7));
            tick(2);
        end
        wait_done();
        chk("slow_ovf", o_overflow, 0);

        wr_mark = wr_cnt;
        start_frame();
        for (int k = 0; k < N; k++) send(24'h220000 + 24'(k * 3));
        wait_done();
        chk("b2b_cnt", wr_cnt - wr_mark, N);
        chk("b2b_span", last_wr - first_wr, N - 1);

        i_waitrequest = 1;
        start_frame();
        for (int k = 0; k < 9; k++) send(24'h330000 + 24'(k), k == 8);
        tick(10);
        chk("stall_ovf", o_overflow, 1);
        chk("stall_write", o_write, 1);
        chk("stall_addr", o_address, BASE);
        chk("stall_data", o_writedata, 24'h330000);
        i_waitrequest = 0;
        tick(15);
        for (int k = 9; k < N; k++) begin
            send(24'h330000 + 24'(k));
            tick(2);
        end
        wait_done();
        chk("ovf_sticky", o_overflow, 1);

        start_frame();
        chk("ovf_cleared", o_overflow, 0);
        for (int k = 0; k < 5; k++) send(24'h440000 + 24'(k));
        start_frame();
        chk("restart_busy", o_busy, 1);
        for (int k = 5; k < N; k++) send(24'h440000 + 24'(k));
        wait_done();

        i_waitrequest = 1;
        start_frame();
        for (int k = 0; k < 3; k++) send(24'h550000 + 24'(k));
        tick(2);
        chk("pre_rst_write", o_write, 1);
        i_rst = 1;
        #1;
        chk("mid_rst_write", o_write, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_addr", o_address, BASE);
        q.delete();
        armed = 0;
        tick(1);
        i_rst = 0;
        i_waitrequest = 0;
        tick(2);
        chk("post_rst_idle", o_write, 0);
        start_frame();
        for (int k = 0; k < N; k++) send(24'h660000 + 24'(k * 5));
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
